hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard unit: forwarding select, stall and flush generation for the in-order 5-stage core.
- Replaces the fixed single-cycle load-use check with a per-register latency scoreboard.
- Covers loads and multi-cycle producers (MUL/DIV), plus WAW ordering and branch-flush priority.
- Sits between Decode and Execute control; also drives a saturating stall-cycle performance counter.

Parameters:
- NUM_REGS, 32, architectural register count (register 0 hardwired zero).
- REG_ADDR_W, 5, register index width; must satisfy 2**REG_ADDR_W >= NUM_REGS.
- MAX_LAT, 7, largest producer latency accepted.
- LAT_W, 3, latency/counter width; must satisfy 2**LAT_W > MAX_LAT.
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ValidDec  in  1  Decode holds a real instruction.
- SourceReg1Dec, SourceReg2Dec  in  REG_ADDR_W  Decode source indices.
- SourceUse1Dec, SourceUse2Dec  in  1  source actually read.
- DestRegDec  in  REG_ADDR_W  Decode destination.
- RegisterWriteDec  in  1  Decode instruction writes DestRegDec.
- LatencyDec  in  LAT_W  cycles from Exec entry until the result is forwardable to an Exec operand (ALU=1, load=2, MUL/DIV up to MAX_LAT).
- SourceReg1Exec, SourceReg2Exec  in  REG_ADDR_W  Exec source indices.
- DestRegMem, DestRegWriteBack  in  REG_ADDR_W  downstream destinations.
- RegisterWriteMem, RegisterWriteWriteBack  in  1  downstream write enables.
- ProgramCounterSourceExec  in  1  taken branch/jump resolved in Exec.
- ForwardingReg1Exec, ForwardingReg2Exec  out  2  00 regfile, 10 Mem result, 01 WB result.
- StallFetch, StallDecode  out  1  hold the Fetch and Decode registers.
- FlushDecode, FlushExec  out  1  clear the Decode and Exec pipeline registers.
- IssueFire  out  1  Decode instruction enters Exec at this edge.
- ScoreboardBusy  out  1  any counter nonzero.
- StallCount  out  CNT_W  saturating count of StallDecode cycles.

Behaviour:
- Reset (async, rst_n=0):
  - all counters cnt[r] = 0; StallCount = 0.
  - Outputs are combinational from state and inputs; with idle inputs all outputs read 0.
- Forwarding (combinational), per Exec source s:
  - 10 if s==DestRegMem && RegisterWriteMem && s!=0.
  - else 01 if s==DestRegWriteBack && RegisterWriteWriteBack && s!=0.
  - else 00. Mem beats WB.
- Counter update, every edge, per register r:
  - if IssueFire && RegisterWriteDec && DestRegDec==r && r!=0: cnt[r] <= max(LatencyDec,1).
  - else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
  - Set wins over decrement. LatencyDec > MAX_LAT is clamped to MAX_LAT.
- RAW hazard: ValidDec and, for a used source s with s!=0, cnt[s] > 1.
  - Load (latency 2) in Exec gives exactly one stall cycle; the consumer then gets the WB forward.
- WAW hazard: ValidDec && RegisterWriteDec && DestRegDec!=0 && cnt[DestRegDec] > clamped LatencyDec.
  - Prevents a short op completing before an older long op to the same register.
- Hazard = RAW | WAW.
- StallFetch = StallDecode = Hazard & ~ProgramCounterSourceExec. A branch redirect overrides the stall because the Decode instruction is squashed.
- FlushDecode = ProgramCounterSourceExec.
- FlushExec = ProgramCounterSourceExec | StallDecode. The bubble is inserted on stall.
- IssueFire = ValidDec & ~StallDecode & ~ProgramCounterSourceExec. A flushed or stalled instruction never sets a counter.
- StallCount increments on each StallDecode cycle and holds at all-ones.
- Register 0: never scoreboarded, never forwarded, never causes a stall.
- Reset mid-operation clears all pending latencies immediately; a stalled pipeline resumes the cycle after rst_n rises.

Test Plan:
- Load then use: issue lw x5 (lat 2), next Decode reads x5 → StallDecode=1 and FlushExec=1 for exactly 1 cycle, then IssueFire=1 and ForwardingReg1Exec=01 in its Exec cycle; StallCount=1.
- MUL x7 (lat 5) then add reading x7 → 4 stall cycles; add enters Exec as the MUL result reaches WB; StallCount=4.
- WAW: div x3 (lat 6), then addi x3 (lat 1) one cycle later → stalled until cnt[x3] ≤ 1 (4 cycles); a subsequent lw x3 (lat 2) stalls 3.
- Forward priority: SourceReg1Exec=DestRegMem=DestRegWriteBack=9, both writes set → 10; same with index 0 → 00; LatencyDec=0 with x0 dest → no stall ever.
- Branch during load stall: lw x4 in Exec, consumer in Decode, ProgramCounterSourceExec=1 → StallDecode=0, FlushDecode=FlushExec=1, IssueFire=0, StallCount unchanged.
- Assert rst_n=0 while cnt[8]=4 → ScoreboardBusy drops to 0 asynchronously, StallCount=0; after release, a read of x8 issues without stall.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode/Exec/Mem/WB control bundle between the pipeline and the hazard scoreboard.
// The pipeline side is the master; the scoreboard is the slave.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = 3,
    parameter int CNT_W      = 32
);
    logic                  ValidDec;
    logic [REG_ADDR_W-1:0] SourceReg1Dec;
    logic [REG_ADDR_W-1:0] SourceReg2Dec;
    logic                  SourceUse1Dec;
    logic                  SourceUse2Dec;
    logic [REG_ADDR_W-1:0] DestRegDec;
    logic                  RegisterWriteDec;
    logic [LAT_W-1:0]      LatencyDec;
    logic [REG_ADDR_W-1:0] SourceReg1Exec;
    logic [REG_ADDR_W-1:0] SourceReg2Exec;
    logic [REG_ADDR_W-1:0] DestRegMem;
    logic [REG_ADDR_W-1:0] DestRegWriteBack;
    logic                  RegisterWriteMem;
    logic                  RegisterWriteWriteBack;
    logic                  ProgramCounterSourceExec;
    logic [1:0]            ForwardingReg1Exec;
    logic [1:0]            ForwardingReg2Exec;
    logic                  StallFetch;
    logic                  StallDecode;
    logic                  FlushDecode;
    logic                  FlushExec;
    logic                  IssueFire;
    logic                  ScoreboardBusy;
    logic [CNT_W-1:0]      StallCount;

    modport master (
        output ValidDec, SourceReg1Dec, SourceReg2Dec, SourceUse1Dec, SourceUse2Dec,
        output DestRegDec, RegisterWriteDec, LatencyDec,
        output SourceReg1Exec, SourceReg2Exec, DestRegMem, DestRegWriteBack,
        output RegisterWriteMem, RegisterWriteWriteBack, ProgramCounterSourceExec,
        input  ForwardingReg1Exec, ForwardingReg2Exec, StallFetch, StallDecode,
        input  FlushDecode, FlushExec, IssueFire, ScoreboardBusy, StallCount
    );

    modport slave (
        input  ValidDec, SourceReg1Dec, SourceReg2Dec, SourceUse1Dec, SourceUse2Dec,
        input  DestRegDec, RegisterWriteDec, LatencyDec,
        input  SourceReg1Exec, SourceReg2Exec, DestRegMem, DestRegWriteBack,
        input  RegisterWriteMem, RegisterWriteWriteBack, ProgramCounterSourceExec,
        output ForwardingReg1Exec, ForwardingReg2Exec, StallFetch, StallDecode,
        output FlushDecode, FlushExec, IssueFire, ScoreboardBusy, StallCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard for the 5-stage core: forwarding selects,
// RAW/WAW stalls, branch flush priority and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_LAT    = 7,
    parameter int LAT_W      = 3,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_scoreboard_if.slave hs
);
    localparam logic [LAT_W-1:0] MAX_LAT_L = LAT_W'(MAX_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    logic [LAT_W-1:0]    lat_clamp;
    logic [LAT_W-1:0]    lat_set;
    logic [NUM_REGS-1:0] src1_sel;
    logic [NUM_REGS-1:0] src2_sel;
    logic [NUM_REGS-1:0] dst_sel;
    logic [NUM_REGS-1:0] pend_vec;
    logic [NUM_REGS-1:0] waw_vec;
    logic [NUM_REGS-1:0] busy_vec;
    logic [NUM_REGS-1:0] set_vec;
    logic                raw_hazard;
    logic                waw_hazard;
    logic                stall;
    logic                issue;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst_mem,
        input logic                  wr_mem,
        input logic [REG_ADDR_W-1:0] dst_wb,
        input logic                  wr_wb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (wr_mem && src == dst_mem)     sel = 2'b10;
            else if (wr_wb && src == dst_wb)  sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        lat_clamp = (hs.LatencyDec > MAX_LAT_L) ? MAX_LAT_L : hs.LatencyDec;
        lat_set   = (lat_clamp == '0) ? LAT_W'(1) : lat_clamp;
    end

    // Register 0 never matches any selector, so it is never scoreboarded or stalled on.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign src1_sel[gi] = (gi != 0) && (hs.SourceReg1Dec == REG_ADDR_W'(gi));
            assign src2_sel[gi] = (gi != 0) && (hs.SourceReg2Dec == REG_ADDR_W'(gi));
            assign dst_sel[gi]  = (gi != 0) && (hs.DestRegDec    == REG_ADDR_W'(gi));
            assign pend_vec[gi] = cnt_q[gi] > LAT_W'(1);
            assign waw_vec[gi]  = cnt_q[gi] > lat_clamp;
            assign busy_vec[gi] = cnt_q[gi] != '0;
            assign set_vec[gi]  = issue && hs.RegisterWriteDec && dst_sel[gi];
        end
    endgenerate

    always_comb begin
        raw_hazard = hs.ValidDec &&
                     ((hs.SourceUse1Dec && |(src1_sel & pend_vec)) ||
                      (hs.SourceUse2Dec && |(src2_sel & pend_vec)));
        waw_hazard = hs.ValidDec && hs.RegisterWriteDec && |(dst_sel & waw_vec);
        // A taken branch squashes the Decode instruction, so it overrides any stall.
        stall      = (raw_hazard || waw_hazard) && !hs.ProgramCounterSourceExec;
        issue      = hs.ValidDec && !stall && !hs.ProgramCounterSourceExec;
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (set_vec[r])             cnt_d[r] = lat_set;
            else if (cnt_q[r] != '0)    cnt_d[r] = cnt_q[r] - LAT_W'(1);
        end
        stall_count_d = stall_count_q;
        if (stall && stall_count_q != CNT_MAX) stall_count_d = stall_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            stall_count_q <= stall_count_d;
        end
    end

    assign hs.ForwardingReg1Exec = fwd_sel(hs.SourceReg1Exec, hs.DestRegMem, hs.RegisterWriteMem,
                                           hs.DestRegWriteBack, hs.RegisterWriteWriteBack);
    assign hs.ForwardingReg2Exec = fwd_sel(hs.SourceReg2Exec, hs.DestRegMem, hs.RegisterWriteMem,
                                           hs.DestRegWriteBack, hs.RegisterWriteWriteBack);
    assign hs.StallFetch     = stall;
    assign hs.StallDecode    = stall;
    assign hs.FlushDecode    = hs.ProgramCounterSourceExec;
    assign hs.FlushExec      = hs.ProgramCounterSourceExec || stall;
    assign hs.IssueFire      = issue;
    assign hs.ScoreboardBusy = |busy_vec;
    assign hs.StallCount     = stall_count_q;
endmodule
